// File: rtl/expand_a_ctrl.sv
// expand_a_ctrl: walks matrix A row-major, running RejNTTPoly once per entry under a per-poly watchdog.
module expand_a_ctrl #(
   parameter int K = 4,
   parameter int L = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] rho,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         rej_start,
   output logic [255:0] rej_rho,
   output logic [7:0]   rej_i,
   output logic [7:0]   rej_j,
   input  logic         rej_done,
   output logic         poly_done,
   output logic [7:0]   poly_row,
   output logic [7:0]   poly_col
);
   localparam int WW = $clog2(TIMEOUT_CYC) + 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN} state_t;
   state_t state, state_nx;
   logic [7:0] row, col;
   logic [WW-1:0] wd;
   logic last_row, last_col, expire;

   if (K < 1 || K > 255 || L < 1 || L > 255 || TIMEOUT_CYC < 2) begin : g_bad_params
      $error("expand_a_ctrl: K and L must be 1..255 and TIMEOUT_CYC at least 2");
   end

   assign last_row = row == 8'(K - 1);
   assign last_col = col == 8'(L - 1);
   // the counter reaches TIMEOUT_CYC-1 on this WAIT cycle's increment
   assign expire = wd == WW'(TIMEOUT_CYC - 2);

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = rej_done ? NEXT : expire ? FIN : WAIT;
         NEXT:    state_nx = (last_row && last_col) ? FIN : ISSUE;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         row <= '0;
         col <= '0;
         wd <= '0;
         err <= 1'b0;
         rej_rho <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               rej_rho <= rho;
               row <= '0;
               col <= '0;
               err <= 1'b0;
            end
            ISSUE: wd <= '0;
            WAIT: begin
               wd <= wd + 1'b1;
               if (!rej_done && expire) err <= 1'b1;
            end
            // the final entry leaves its indices in place until the next start
            NEXT: if (!(last_row && last_col)) begin
               col <= last_col ? 8'd0 : col + 8'd1;
               row <= last_col ? row + 8'd1 : row;
            end
            default: ;
         endcase
      end

   assign busy = state != IDLE;
   assign done = state == FIN;
   assign rej_start = state == ISSUE;
   assign poly_done = state == NEXT;
   assign poly_row = poly_done ? row : 8'd0;
   assign poly_col = poly_done ? col : 8'd0;
   assign rej_i = row;
   assign rej_j = col;
endmodule

// File: tb/tb_expand_a_ctrl.sv
// tb_expand_a_ctrl: timestamp-based reference model plus directed sweeps with literal expectations.
module tb_expand_a_ctrl;
   localparam int K = 4, L = 4, T = 64;
   localparam logic [255:0] RHO1 = 256'h0f2ebf0e_3c5a7d91_b4e26f08_17c9a3d5_e2804b6f_9d31c7a2_5b6e08f4_47da1f1c;
   localparam logic [255:0] RHO2 = 256'ha5a5_1234_5678_9abc_def0_0fed_cba9_8765_4321_5a5a_c3c3_3c3c_0000_ffff_1111_eeee;

   logic clk = 1'b0, rst, start, rej_done;
   logic [255:0] rho, rej_rho;
   logic busy, done, err, rej_start, poly_done;
   logic [7:0] rej_i, rej_j, poly_row, poly_col;

   expand_a_ctrl #(.K(K), .L(L), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst), .start(start), .rho(rho), .busy(busy), .done(done), .err(err),
      .rej_start(rej_start), .rej_rho(rej_rho), .rej_i(rej_i), .rej_j(rej_j), .rej_done(rej_done),
      .poly_done(poly_done), .poly_row(poly_row), .poly_col(poly_col)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model: cycle numbers at which each output event is due, derived from the sweep rules
   bit m_active = 0, m_err = 0;
   int m_k = 0, issue_at = -1, pdone_at = -1, fin_at = -1;
   logic [255:0] m_rho = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_active <= 0; m_err <= 0; m_k <= 0; m_rho <= '0;
         issue_at <= -1; pdone_at <= -1; fin_at <= -1;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1; m_rho <= rho; m_k <= 0; m_err <= 0; issue_at <= cyc + 1;
         end
      end else if (cyc == fin_at) begin
         m_active <= 0; fin_at <= -1;
      end else if (cyc == pdone_at) begin
         pdone_at <= -1;
         if (m_k == K * L - 1) fin_at <= cyc + 1;
         else begin
            m_k <= m_k + 1; issue_at <= cyc + 1;
         end
      end else if (issue_at >= 0 && cyc > issue_at) begin
         if (rej_done) begin
            pdone_at <= cyc + 1; issue_at <= -1;
         end else if (cyc == issue_at + T - 1) begin
            m_err <= 1; fin_at <= cyc + 1; issue_at <= -1;
         end
      end
   end

   // RejNTTPoly stand-in: answers `delay` cycles after each rej_start unless the entry is dropped
   int delay = 10, drop = -1, ans_at = -1;
   bit stray = 0, stray_next = 0;
   initial begin
      rej_done = 1'b0;
      forever begin
         @(negedge clk);
         rej_done = stray || (cyc == ans_at) || (stray_next && poly_done);
         if (rej_start && m_k != drop) ans_at = cyc + delay;
      end
   end

   int n_issue, n_pdone, last_issue, min_gap, max_gap, t_done, t_pdone, t_start;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("busy", busy, m_active);
         check("done", done, cyc == fin_at);
         check("err", err, m_err);
         check("rej_start", rej_start, cyc == issue_at);
         check("poly_done", poly_done, cyc == pdone_at);
         check("rej_i", rej_i, m_k / L);
         check("rej_j", rej_j, m_k % L);
         check("rej_rho", rej_rho, m_rho);
         check("poly_row", poly_row, cyc == pdone_at ? m_k / L : 0);
         check("poly_col", poly_col, cyc == pdone_at ? m_k % L : 0);
         if (rej_start) begin
            if (last_issue >= 0) begin
               min_gap = (cyc - last_issue < min_gap) ? cyc - last_issue : min_gap;
               max_gap = (cyc - last_issue > max_gap) ? cyc - last_issue : max_gap;
            end
            last_issue = cyc;
            n_issue++;
         end
         if (poly_done) begin
            n_pdone++;
            t_pdone = cyc;
         end
         if (done) t_done = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      n_issue = 0; n_pdone = 0; last_issue = -1; min_gap = 1000000; max_gap = 0;
   endtask

   task automatic kick(input logic [255:0] r);
      clr();
      rho = r;
      start = 1'b1;
      t_start = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         seen = done;
      end
      check("done_seen", seen, 1'b1);
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; rho = '0;
      clr();
      tick(); tick();
      chk_en = 1;
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rho", rej_rho, 256'h0);
      rst = 1'b0;
      tick();
      // stray rej_done while idle
      clr();
      stray = 1; tick(); stray = 0;
      repeat (3) tick();
      check("idle_stray_pdone", n_pdone, 0);

      // normal sweep with a second start mid-sweep that must be ignored
      kick(RHO1);
      repeat (30) tick();
      rho = RHO2; start = 1'b1; tick(); start = 1'b0;
      wait_done(2000);
      check("a_issues", n_issue, 16);
      check("a_pdones", n_pdone, 16);
      check("a_gap_min", min_gap, 12);
      check("a_gap_max", max_gap, 12);
      check("a_done_lat", t_done - t_pdone, 1);
      check("a_rho_kept", rej_rho, RHO1);
      check("a_err", err, 1'b0);
      check("a_busy_low", busy, 1'b0);
      check("a_hold_i", rej_i, 8'd3);
      check("a_hold_j", rej_j, 8'd3);

      // immediate core with stray rej_done during every NEXT
      delay = 1; stray_next = 1;
      kick(RHO2);
      wait_done(500);
      stray_next = 0;
      check("b_gap_min", min_gap, 3);
      check("b_gap_max", max_gap, 3);
      check("b_total", t_done - t_start + 1, 1 + 16 * 3 + 1);
      check("b_pdones", n_pdone, 16);
      check("b_rho", rej_rho, RHO2);

      // core answers on the last permitted cycle: accepted, no error
      delay = T - 1;
      kick(RHO1);
      wait_done(3000);
      check("c_err", err, 1'b0);
      check("c_pdones", n_pdone, 16);

      // entry (1,2) never answered
      delay = 10; drop = 6;
      kick(RHO1);
      wait_done(2000);
      check("d_err", err, 1'b1);
      check("d_pdones", n_pdone, 6);
      check("d_to_lat", t_done - last_issue, T);
      repeat (3) tick();
      check("d_hold_i", rej_i, 8'd1);
      check("d_hold_j", rej_j, 8'd2);
      check("d_err_sticky", err, 1'b1);

      // restart clears err, then reset lands in WAIT of (2,1)
      drop = -1;
      kick(RHO2);
      check("e_err_clr", err, 1'b0);
      check("e_first_start", rej_start, 1'b1);
      check("e_first_i", rej_i, 8'd0);
      check("e_first_j", rej_j, 8'd0);
      begin
         bit found = 0;
         for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            found = rej_start && rej_i == 8'd2 && rej_j == 8'd1;
         end
         check("e_reach_21", found, 1'b1);
      end
      repeat (3) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("e_rst_busy", busy, 1'b0);
      check("e_rst_i", rej_i, 8'd0);
      check("e_rst_j", rej_j, 8'd0);
      check("e_rst_rho", rej_rho, 256'h0);
      clr();
      repeat (12) tick();
      stray = 1; tick(); stray = 0;
      repeat (3) tick();
      check("e_post_pdone", n_pdone, 0);
      check("e_post_issue", n_issue, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/expand_a_ctrl.md
Name: expand_a_ctrl

Overview:
- Sequencer that expands the public matrix A (K x L polynomials in NTT domain) by driving the existing RejNTTPoly core once per matrix entry.
- Latches seed rho on start, walks indices in row-major order (i = row 0..K-1, j = col 0..L-1), pulses the core's start, waits for its done, and reports each completed polynomial with its (row, col) tag.
- Sits between the top-level key-gen/sign/verify controller and a single RejNTTPoly instance; includes a per-poly watchdog.

Parameters:
- K, 4, matrix rows (ML-DSA-44 = 4; 6 and 8 also legal).
- L, 4, matrix columns (ML-DSA-44 = 4; 5 and 7 also legal).
- TIMEOUT_CYC, 4096, maximum cycles allowed between rej_start and rej_done before an error abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to expand A; sampled only in IDLE.
- rho  in  256  seed; captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse when the sweep ends (normal or error).
- err  out  1  sticky timeout flag; cleared on the next accepted start or by rst.
- rej_start  out  1  one-cycle start pulse to RejNTTPoly.
- rej_rho  out  256  latched seed to RejNTTPoly; held stable for the whole sweep.
- rej_i  out  8  current row index to RejNTTPoly.
- rej_j  out  8  current column index to RejNTTPoly.
- rej_done  in  1  completion pulse from RejNTTPoly.
- poly_done  out  1  one-cycle pulse; the poly at (poly_row, poly_col) is complete.
- poly_row  out  8  row tag; valid with poly_done.
- poly_col  out  8  column tag; valid with poly_done.

Behaviour:
- Reset values (rst high at a clk edge): state IDLE, all outputs 0, rej_rho 0, row/col counters 0, watchdog 0. Reset overrides every state, including mid-sweep. No rej_start is issued in the reset cycle or the cycle after it.
- States and transitions:
  - IDLE: on start, latch rho, clear counters and err, go to ISSUE.
  - ISSUE: rej_start=1 for exactly this cycle, watchdog cleared, go to WAIT.
  - WAIT: watchdog increments each cycle.
    - rej_done=1: go to NEXT.
    - Otherwise, if watchdog reaches TIMEOUT_CYC-1: set err, go to FIN.
  - NEXT: poly_done=1 with poly_row/poly_col = current row/col. Then:
    - If col = L-1 and row = K-1: go to FIN.
    - Else if col = L-1: col=0, row+1, go to ISSUE.
    - Else: col+1, go to ISSUE.
  - FIN: done=1 for one cycle, go to IDLE.
- rej_i and rej_j mirror the row and col counters and are stable from ISSUE through NEXT.
- busy = (state != IDLE).
- Latency:
  - start sampled at edge n -> rej_start high during cycle n+1.
  - rej_done sampled in WAIT at edge m -> poly_done during cycle m+1 -> next rej_start during cycle m+2.
  - Last poly_done at cycle t -> done at t+1; busy low at t+2.
- Boundary rules:
  - start while busy is ignored; rho is not re-latched.
  - rej_done outside WAIT is ignored; it does not advance counters.
  - rej_done in the same cycle the watchdog expires: rej_done wins, no error.
  - On timeout: no poly_done for the failed entry; counters freeze at the failing index (visible on rej_i/rej_j until IDLE).
  - After done, rej_i and rej_j hold their last values until the next start.
- Widths: counters are 8 bits; K and L must be at most 255 (elaboration check).

Test Plan:
- Normal sweep: K=4, L=4, rho=0f2ebf0e...da1f1c; model returns rej_done 10 cycles after each rej_start -> exactly 16 rej_start pulses with (i,j) = (0,0),(0,1)...(3,3) in order; 16 poly_done pulses with matching tags; a single done one cycle after the last poly_done; err=0; rej_rho equals rho throughout.
- Immediate core: rej_done returned the cycle after rej_start -> rej_start spacing is exactly 3 cycles; start-to-done = 1 + 16*3 + 1 cycles.
- Busy re-start: second start with a different rho mid-sweep -> ignored; rej_rho unchanged; sweep completes with 16 entries.
- Timeout: TIMEOUT_CYC=64, model never answers entry (1,2) -> err=1 and done pulses 64 cycles after that rej_start; 6 poly_done pulses observed; rej_i=1, rej_j=2 held. A following start clears err and restarts at (0,0).
- Reset mid-operation: rst asserted in WAIT of entry (2,1) -> next cycle all outputs 0, state IDLE; a spurious rej_done afterwards produces no poly_done.
- Stray rej_done while IDLE and during NEXT -> no counter advance, no extra poly_done.
